// File: rtl/icarus_branch_pkg.sv
// Shared comparator control codes and resolver state encoding for the ICARUS branch path.
// The target-address helper lives here so anything else computing branch targets gets identical arithmetic.
package icarus_branch_pkg;

    localparam logic [2:0] CTRL_BEQ  = 3'd0;
    localparam logic [2:0] CTRL_BGEZ = 3'd1;
    localparam logic [2:0] CTRL_BGTZ = 3'd2;
    localparam logic [2:0] CTRL_BLEZ = 3'd3;
    localparam logic [2:0] CTRL_BLTZ = 3'd4;
    localparam logic [2:0] CTRL_BNE  = 3'd5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMPARE  = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    // Target = PC+4 of the branch plus the word offset; wraps silently modulo 2^32.
    function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [15:0] offset);
        return pc + {{14{offset[15]}}, offset, 2'b00};
    endfunction

endpackage

// File: rtl/branch_stats_counter.sv
// 32-bit saturating event counter with synchronous active-high clear.
module branch_stats_counter (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    output logic [31:0] count
);

    always_ff @(posedge clock) begin
        if (reset)
            count <= '0;
        else if (enable && (count != 32'hFFFF_FFFF))
            count <= count + 32'd1;
    end

endmodule

// File: rtl/branch_resolver.sv
// ID-stage branch resolver: drives the comparator, samples its result and issues a handshaked PC redirect.
// Define BRANCH_STATS_EN to add the BranchCount/TakenCount statistics ports.
module branch_resolver
    import icarus_branch_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        BrValid,
    output logic        BrReady,
    input  logic [2:0]  BrOp,
    input  logic [31:0] BrPC,
    input  logic [15:0] BrOffset,
    input  logic [31:0] RsData,
    input  logic [31:0] RtData,
    input  logic        RegimmRt,
    output logic [31:0] CmpA,
    output logic [31:0] CmpB,
    output logic [2:0]  CmpControl,
    input  logic        CmpResult,
    output logic        ResolveValid,
    output logic        Taken,
    output logic        IllegalOp,
    output logic        RedirectValid,
    input  logic        RedirectReady,
    output logic [31:0] RedirectPC,
`ifdef BRANCH_STATS_EN
    output logic [31:0] BranchCount,
    output logic [31:0] TakenCount,
`endif
    output logic        Flush
);

    state_t      state;
    state_t      next_state;

    logic [2:0]  op_q;
    logic [31:0] pc_q;
    logic [15:0] offset_q;
    logic [31:0] rs_q;
    logic [31:0] rt_q;
    logic        regimm_q;

    logic        resolve_q;
    logic        taken_q;
    logic        illegal_q;

    logic        op_illegal;
    logic        take_branch;

    assign op_illegal  = (op_q > CTRL_BNE);
    assign take_branch = !op_illegal && CmpResult;

    always_ff @(posedge Clock) begin
        if (Reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Captured operands also feed the comparator outputs, so they hold their last value outside COMPARE.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            op_q     <= '0;
            pc_q     <= '0;
            offset_q <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            regimm_q <= 1'b0;
        end else if ((state == IDLE) && BrValid) begin
            op_q     <= BrOp;
            pc_q     <= BrPC;
            offset_q <= BrOffset;
            rs_q     <= RsData;
            rt_q     <= RtData;
            regimm_q <= RegimmRt;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            resolve_q <= 1'b0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            resolve_q <= (state == COMPARE);
            taken_q   <= (state == COMPARE) && take_branch;
            illegal_q <= (state == COMPARE) && op_illegal;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (BrValid) next_state = COMPARE;
            COMPARE:  next_state = take_branch ? REDIRECT : IDLE;
            REDIRECT: if (RedirectReady) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // REGIMM branches hand the comparator the sign-test selector instead of Rt.
    always_comb begin
        CmpB = rt_q;
        case (op_q)
            CTRL_BGEZ, CTRL_BLTZ:                    CmpB = {31'b0, regimm_q};
            CTRL_BEQ, CTRL_BGTZ, CTRL_BLEZ, CTRL_BNE: CmpB = rt_q;
            default:                                 CmpB = rt_q;
        endcase
    end

    always_comb begin
        BrReady       = (state == IDLE) && !Reset;
        RedirectValid = (state == REDIRECT);
        Flush         = (state == REDIRECT) && resolve_q;
        CmpA          = rs_q;
        CmpControl    = op_q;
        RedirectPC    = branch_target(pc_q, offset_q);
        ResolveValid  = resolve_q;
        Taken         = taken_q;
        IllegalOp     = illegal_q;
    end

`ifdef BRANCH_STATS_EN
    branch_stats_counter u_branch_count (
        .clock  (Clock),
        .reset  (Reset),
        .enable (resolve_q),
        .count  (BranchCount)
    );

    branch_stats_counter u_taken_count (
        .clock  (Clock),
        .reset  (Reset),
        .enable (resolve_q && taken_q),
        .count  (TakenCount)
    );
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver with a behavioural comparator that evaluates on the falling edge.
// Statistics checks are compiled in when BRANCH_STATS_EN is defined.
module tb_branch_resolver;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        BrValid;
    logic        BrReady;
    logic [2:0]  BrOp;
    logic [31:0] BrPC;
    logic [15:0] BrOffset;
    logic [31:0] RsData;
    logic [31:0] RtData;
    logic        RegimmRt;
    logic [31:0] CmpA;
    logic [31:0] CmpB;
    logic [2:0]  CmpControl;
    logic        CmpResult;
    logic        ResolveValid;
    logic        Taken;
    logic        IllegalOp;
    logic        RedirectValid;
    logic        RedirectReady;
    logic [31:0] RedirectPC;
    logic        Flush;
`ifdef BRANCH_STATS_EN
    logic [31:0] BranchCount;
    logic [31:0] TakenCount;
`endif

    int testCount = 0;
    int failCount = 0;

    always #5 Clock = ~Clock;

    branch_resolver dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .BrValid       (BrValid),
        .BrReady       (BrReady),
        .BrOp          (BrOp),
        .BrPC          (BrPC),
        .BrOffset      (BrOffset),
        .RsData        (RsData),
        .RtData        (RtData),
        .RegimmRt      (RegimmRt),
        .CmpA          (CmpA),
        .CmpB          (CmpB),
        .CmpControl    (CmpControl),
        .CmpResult     (CmpResult),
        .ResolveValid  (ResolveValid),
        .Taken         (Taken),
        .IllegalOp     (IllegalOp),
        .RedirectValid (RedirectValid),
        .RedirectReady (RedirectReady),
        .RedirectPC    (RedirectPC),
`ifdef BRANCH_STATS_EN
        .BranchCount   (BranchCount),
        .TakenCount    (TakenCount),
`endif
        .Flush         (Flush)
    );

    // Illegal codes return 1 so a resolver that fails to ignore the comparator shows up as taken.
    always @(negedge Clock) begin
        case (CmpControl)
            3'd0:       CmpResult = (CmpA == CmpB);
            3'd1, 3'd4: CmpResult = CmpB[0] ? !CmpA[31] : CmpA[31];
            3'd2:       CmpResult = ($signed(CmpA) >  $signed(CmpB));
            3'd3:       CmpResult = ($signed(CmpA) <= $signed(CmpB));
            3'd5:       CmpResult = (CmpA != CmpB);
            default:    CmpResult = 1'b1;
        endcase
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic waitReady();
        int n = 0;
        while ((BrReady !== 1'b1) && (n < 20)) begin
            stepCycle();
            n++;
        end
        if (BrReady !== 1'b1)
            checkOutput("ready_timeout", {31'b0, BrReady}, 32'd1);
    endtask

    // Offers one branch, checks the comparator drive during COMPARE and returns in the resolve cycle.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] pc, input logic [15:0] offset,
                                 input logic [31:0] rs, input logic [31:0] rt, input logic regimm,
                                 input logic [31:0] expCmpB);
        waitReady();
        BrOp     = op;
        BrPC     = pc;
        BrOffset = offset;
        RsData   = rs;
        RtData   = rt;
        RegimmRt = regimm;
        BrValid  = 1'b1;
        stepCycle();
        BrValid  = 1'b0;
        checkOutput("cmp_control", {29'b0, CmpControl}, {29'b0, op});
        checkOutput("cmp_a", CmpA, rs);
        checkOutput("cmp_b", CmpB, expCmpB);
        checkOutput("ready_in_compare", {31'b0, BrReady}, 32'd0);
        stepCycle();
    endtask

    task automatic checkResolve(input logic expTaken, input logic expIllegal, input logic [31:0] expPC);
        checkOutput("resolve_valid", {31'b0, ResolveValid}, 32'd1);
        checkOutput("taken", {31'b0, Taken}, {31'b0, expTaken});
        checkOutput("illegal_op", {31'b0, IllegalOp}, {31'b0, expIllegal});
        checkOutput("redirect_valid", {31'b0, RedirectValid}, {31'b0, expTaken});
        checkOutput("flush", {31'b0, Flush}, {31'b0, expTaken});
        checkOutput("ready_after_resolve", {31'b0, BrReady}, {31'b0, !expTaken});
        if (expTaken)
            checkOutput("redirect_pc", RedirectPC, expPC);
    endtask

    initial begin
        Reset         = 1'b1;
        BrValid       = 1'b0;
        BrOp          = 3'd0;
        BrPC          = '0;
        BrOffset      = '0;
        RsData        = '0;
        RtData        = '0;
        RegimmRt      = 1'b0;
        RedirectReady = 1'b1;
        CmpResult     = 1'b0;

        stepCycle();
        stepCycle();
        checkOutput("reset_ready_low", {31'b0, BrReady}, 32'd0);
        Reset = 1'b0;
        #1;
        checkOutput("reset_ready", {31'b0, BrReady}, 32'd1);
        checkOutput("reset_redirect_valid", {31'b0, RedirectValid}, 32'd0);
        checkOutput("reset_flush", {31'b0, Flush}, 32'd0);
        checkOutput("reset_resolve", {31'b0, ResolveValid}, 32'd0);
        checkOutput("reset_taken", {31'b0, Taken}, 32'd0);
        checkOutput("reset_illegal", {31'b0, IllegalOp}, 32'd0);
        checkOutput("reset_cmp_a", CmpA, 32'd0);
        checkOutput("reset_cmp_b", CmpB, 32'd0);
        checkOutput("reset_cmp_control", {29'b0, CmpControl}, 32'd0);
        checkOutput("reset_redirect_pc", RedirectPC, 32'd0);

        // BEQ taken: 0x100 + (4 << 2) = 0x110
        applyStimulus(3'd0, 32'h100, 16'h0004, 32'h1234, 32'h1234, 1'b0, 32'h1234);
        checkResolve(1'b1, 1'b0, 32'h110);
        stepCycle();
        checkOutput("beq_flush_once", {31'b0, Flush}, 32'd0);
        checkOutput("beq_redirect_done", {31'b0, RedirectValid}, 32'd0);
        checkOutput("beq_ready_again", {31'b0, BrReady}, 32'd1);

        // BGEZ of a negative value: selector 1, not taken
        applyStimulus(3'd1, 32'h200, 16'h0008, 32'h8000_0000, 32'h55, 1'b1, 32'd1);
        checkResolve(1'b0, 1'b0, 32'h0);

        // BLTZ of the same value: selector 0, taken; 0x200 + 0x20 = 0x220
        applyStimulus(3'd4, 32'h200, 16'h0008, 32'h8000_0000, 32'h77, 1'b0, 32'd0);
        checkResolve(1'b1, 1'b0, 32'h220);

        // BNE taken with negative offset wrapping below zero
        applyStimulus(3'd5, 32'h4, 16'hFFFE, 32'd1, 32'd2, 1'b0, 32'd2);
        checkResolve(1'b1, 1'b0, 32'hFFFF_FFFC);

        // BLEZ of a positive value: not taken
        applyStimulus(3'd3, 32'h400, 16'h0001, 32'd5, 32'd0, 1'b0, 32'd0);
        checkResolve(1'b0, 1'b0, 32'h0);
`ifdef BRANCH_STATS_EN
        stepCycle();
        checkOutput("stats_branch_count", BranchCount, 32'd5);
        checkOutput("stats_taken_count", TakenCount, 32'd3);
`endif

        // BGTZ taken with three cycles of redirect backpressure; 0x2000 + 0x40 = 0x2040
        RedirectReady = 1'b0;
        applyStimulus(3'd2, 32'h2000, 16'h0010, 32'd5, 32'd0, 1'b0, 32'd0);
        checkResolve(1'b1, 1'b0, 32'h2040);
        for (int i = 0; i < 4; i++) begin
            if (i == 3)
                RedirectReady = 1'b1;
            checkOutput("bp_redirect_valid", {31'b0, RedirectValid}, 32'd1);
            checkOutput("bp_redirect_pc", RedirectPC, 32'h2040);
            checkOutput("bp_flush", {31'b0, Flush}, (i == 0) ? 32'd1 : 32'd0);
            checkOutput("bp_ready_low", {31'b0, BrReady}, 32'd0);
            stepCycle();
        end
        checkOutput("bp_redirect_released", {31'b0, RedirectValid}, 32'd0);
        checkOutput("bp_ready_again", {31'b0, BrReady}, 32'd1);

        // Reset while a redirect is pending drops it
        RedirectReady = 1'b0;
        applyStimulus(3'd0, 32'h300, 16'h0001, 32'd7, 32'd7, 1'b0, 32'd7);
        checkResolve(1'b1, 1'b0, 32'h304);
        Reset = 1'b1;
        stepCycle();
        checkOutput("rst_mid_ready_low", {31'b0, BrReady}, 32'd0);
        Reset = 1'b0;
        #1;
        checkOutput("rst_mid_redirect_valid", {31'b0, RedirectValid}, 32'd0);
        checkOutput("rst_mid_ready", {31'b0, BrReady}, 32'd1);
        checkOutput("rst_mid_redirect_pc", RedirectPC, 32'd0);
        checkOutput("rst_mid_cmp_a", CmpA, 32'd0);
        RedirectReady = 1'b1;

        // Illegal op 7: comparator says true but the branch is forced not-taken
        applyStimulus(3'd7, 32'h500, 16'h0010, 32'd9, 32'd9, 1'b0, 32'd9);
        checkResolve(1'b0, 1'b1, 32'h0);
        stepCycle();
        checkOutput("illegal_pulse_once", {31'b0, IllegalOp}, 32'd0);
        checkOutput("illegal_no_redirect", {31'b0, RedirectValid}, 32'd0);
`ifdef BRANCH_STATS_EN
        checkOutput("stats_after_reset_branch", BranchCount, 32'd1);
        checkOutput("stats_after_reset_taken", TakenCount, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Branch resolution unit for the ICARUS MIPS pipeline, sitting in the ID stage on the driving side of the branch comparator. It accepts a decoded branch, encodes and drives the comparator's 3-bit control code and operands, and samples the comparator's 1-bit result. It then computes the branch target and issues a handshaked PC redirect plus a one-cycle IF/ID flush to the fetch unit when the branch is taken.

## Interface
- No parameters; data width fixed at 32.
- `Clock` in 1: single clock, rising edge. The comparator evaluates on the falling edge of the same clock.
- `Reset` in 1: synchronous, active-high.
- `BrValid` in 1: decoded branch offered.
- `BrReady` out 1: block can accept a branch (high only in IDLE).
- `BrOp` in 3: 0=BEQ, 1=BGEZ, 2=BGTZ, 3=BLEZ, 4=BLTZ, 5=BNE; 6 and 7 are illegal.
- `BrPC` in 32: PC+4 of the branch.
- `BrOffset` in 16: immediate offset field.
- `RsData`, `RtData` in 32 each: forwarded register operands.
- `RegimmRt` in 1: rt[0] of REGIMM branches.
- `CmpA`, `CmpB` out 32 each: comparator operands.
- `CmpControl` out 3: comparator control code.
- `CmpResult` in 1: comparator result.
- `ResolveValid` out 1: one-cycle pulse when a branch is resolved.
- `Taken` out 1: outcome, qualified by `ResolveValid`.
- `IllegalOp` out 1: one-cycle pulse, aligned with `ResolveValid`, for BrOp 6 or 7.
- `RedirectValid` out 1: redirect request to fetch.
- `RedirectReady` in 1: fetch accepts the redirect.
- `RedirectPC` out 32: branch target.
- `Flush` out 1: IF/ID flush pulse.

## Operation
- FSM has three states: IDLE, COMPARE, REDIRECT. Reset state is IDLE.
- **IDLE:**
  - `BrReady`=1.
  - On `BrValid`&`BrReady`, capture BrOp, BrPC, BrOffset, RsData, RtData and RegimmRt into internal registers, then go to COMPARE.
- **COMPARE:** outputs are driven from the captured registers and held stable for the whole cycle.
  - `CmpControl`=op.
  - `CmpA`=Rs.
  - `CmpB`: for BGEZ/BLTZ, `{31'b0, RegimmRt}`. A value of 1 means "A>=0" and 0 means "A<0". For all other ops, `CmpB`=Rt.
  - BGTZ/BLEZ: `CmpB`=Rt as captured; decode supplies zero.
  - At the closing rising edge, sample `CmpResult` into the taken flag and pulse `ResolveValid` for the next cycle.
  - Taken: go to REDIRECT. Not taken: go to IDLE.
  - Illegal op: forced not-taken, `IllegalOp` pulses, and `CmpResult` is ignored.
- **REDIRECT:**
  - `RedirectValid`=1 and `RedirectPC` is held until `RedirectValid`&`RedirectReady`, then go to IDLE.
  - `Flush`=1 on the first REDIRECT cycle only.
- **Target arithmetic:** `RedirectPC` = BrPC + (sign-extended BrOffset << 2), modulo 2^32 with silent wrap. Computed combinationally from the captured registers.
- **Reset mid-operation:** returns to IDLE. Any pending redirect is dropped and all outputs go to their reset values. A branch offered during the reset cycle is not accepted.

## Timing
- Reset values:
  - `BrReady`=1 once out of reset; 0 while `Reset` is asserted.
  - `RedirectValid`, `Flush`, `ResolveValid`, `Taken`, `IllegalOp` = 0.
  - `CmpA`, `CmpB`, `RedirectPC` = 0; `CmpControl`=0.
- Accept at edge k. `CmpResult` is valid after the falling edge of cycle k..k+1.
- `ResolveValid`, `Taken`, `RedirectValid` and `Flush` are all high in cycle k+1..k+2.
- Not taken: `BrReady` is high again in cycle k+1..k+2, so throughput is 1 branch per 2 cycles.
- Taken with `RedirectReady`=1: back in IDLE at edge k+2. Each cycle of `RedirectReady`=0 adds one cycle; `Flush` is not repeated.
- `Cmp*` outputs keep their last value outside COMPARE.

## Configuration
- `BRANCH_STATS_EN` defined:
  - Adds output ports `BranchCount` (out, 32) and `TakenCount` (out, 32).
  - Both increment on `ResolveValid` (`TakenCount` only when `Taken`), saturate at 0xFFFFFFFF, and clear on `Reset`.
  - Illegal ops count as branches, not-taken.
- `BRANCH_STATS_EN` undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Package `icarus_branch_pkg` holds the control-code localparams (BEQ..BNE, values 0–5) shared with the comparator, plus the state encoding (IDLE=0, COMPARE=1, REDIRECT=2).
- One sub-module, `branch_stats_counter` (32-bit saturating counter with enable), instantiated twice under `BRANCH_STATS_EN`.

## Test plan
- **BEQ taken:** Rs=Rt=0x1234, BrPC=0x100, offset=0x0004 -> `CmpControl`=0 in cycle k+1. Next cycle: `Taken`=1, `RedirectPC`=0x110, `Flush` high for 1 cycle.
- **BGEZ/BLTZ:**
  - BGEZ (RegimmRt=1), Rs=0x80000000 -> `CmpB`=1, not taken, `BrReady` high at cycle k+1.
  - BLTZ (RegimmRt=0), same Rs -> `CmpB`=0, taken.
- **Negative offset wrap:** BrPC=0x4, offset=0xFFFE -> `RedirectPC`=0xFFFFFFFC.
- **Redirect backpressure:** `RedirectReady` low for 3 cycles -> `RedirectValid` and `RedirectPC` held for 4 cycles, `Flush` exactly 1 cycle, `BrReady` low throughout.
- **Reset in REDIRECT:** assert `Reset` 1 cycle -> next cycle `RedirectValid`=0, `BrReady`=1. BrOp=7 afterwards -> `IllegalOp`=1, `Taken`=0, no redirect.
- **With `BRANCH_STATS_EN`:** 3 taken + 2 not-taken branches -> `BranchCount`=5, `TakenCount`=3.
